// File: rtl/squeeze_unit.sv
// Keccak squeeze stage: streams rate-limited bytes of the sponge state as 32-byte beats,
// requesting a permutation whenever a full rate block has been emitted.

package keccak_pkg;
   localparam int unsigned ROW_SIZE   = 5;
   localparam int unsigned COL_SIZE   = 5;
   localparam int unsigned LANE_SIZE  = 64;
   localparam int unsigned DWIDTH     = 256;
   localparam int unsigned KEEP_WIDTH = 32;
   localparam int unsigned RATE_WIDTH = 11;
   localparam int unsigned STATE_BITS = ROW_SIZE * COL_SIZE * LANE_SIZE;
endpackage

module squeeze_unit
   import keccak_pkg::*;
#(
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_i,
   input  logic [RATE_WIDTH-1:0]                              rate_i,
   input  logic                                               start_i,
   input  logic [LEN_WIDTH-1:0]                               out_len_i,
   output logic [DWIDTH-1:0]                                  data_o,
   output logic [KEEP_WIDTH-1:0]                              keep_o,
   output logic                                               valid_o,
   input  logic                                               ready_i,
   output logic                                               last_o,
   output logic                                               perm_req_o,
   input  logic                                               perm_done_i,
   output logic                                               busy_o,
   output logic                                               done_o
);

   localparam int unsigned RB_W    = RATE_WIDTH - 3;
   localparam int unsigned N_W     = $clog2(KEEP_WIDTH) + 1;
   localparam int unsigned SHIFT_W = RB_W + 3;
   localparam int unsigned KW1     = KEEP_WIDTH + 1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_EMIT      = 2'd1;
   localparam logic [1:0] ST_PERM_WAIT = 2'd2;

   logic [1:0]            state_q, state_nxt;
   logic [RB_W-1:0]       offset_q, offset_nxt;
   logic [RB_W-1:0]       rate_bytes_q, rate_bytes_nxt;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_nxt;
   logic [N_W-1:0]        cur_n, n_nxt;
   logic [RB_W-1:0]       off_sum;
   logic [SHIFT_W-1:0]    shamt;
   logic [STATE_BITS-1:0] flat;
   logic [DWIDTH-1:0]     byte_mask;
   logic [DWIDTH-1:0]     data_nxt;
   logic [KEEP_WIDTH-1:0] keep_nxt;
   logic                  last_nxt;
   logic                  done_nxt;
   logic                  hs;

   // Beat size: limited by bus width, bytes left in the rate block, and bytes left to send
   function automatic logic [N_W-1:0] beat_len(input logic [RB_W-1:0]      rb,
                                               input logic [RB_W-1:0]      off,
                                               input logic [LEN_WIDTH-1:0] rem);
      logic [RB_W-1:0]      avail;
      logic [LEN_WIDTH-1:0] m;
      avail = rb - off;
      m     = LEN_WIDTH'(KEEP_WIDTH);
      if (LEN_WIDTH'(avail) < m) m = LEN_WIDTH'(avail);
      if (rem < m) m = rem;
      return N_W'(m);
   endfunction

   // Lane L lives at x = L mod 5, y = L / 5; flatten so state byte k sits at bits [8k+7:8k]
   always_comb begin
      flat = '0;
      for (int l = 0; l < ROW_SIZE * COL_SIZE; l++) begin
         flat[l*LANE_SIZE +: LANE_SIZE] = state_array_i[l % ROW_SIZE][l / ROW_SIZE];
      end
   end

   assign hs = valid_o & ready_i;

   always_comb begin
      state_nxt      = state_q;
      offset_nxt     = offset_q;
      remaining_nxt  = remaining_q;
      rate_bytes_nxt = rate_bytes_q;
      done_nxt       = 1'b0;
      cur_n          = beat_len(rate_bytes_q, offset_q, remaining_q);
      off_sum        = offset_q + RB_W'(cur_n);

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (out_len_i != '0) begin
                  rate_bytes_nxt = RB_W'(rate_i >> 3);
                  remaining_nxt  = out_len_i;
                  offset_nxt     = '0;
                  state_nxt      = ST_EMIT;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         ST_EMIT: begin
            if (hs) begin
               // Final beat wins over the rate edge so no permutation is requested after it
               if (last_o) begin
                  state_nxt     = ST_IDLE;
                  done_nxt      = 1'b1;
                  offset_nxt    = '0;
                  remaining_nxt = '0;
               end else if (off_sum == rate_bytes_q) begin
                  offset_nxt    = '0;
                  remaining_nxt = remaining_q - LEN_WIDTH'(cur_n);
                  state_nxt     = ST_PERM_WAIT;
               end else begin
                  offset_nxt    = off_sum;
                  remaining_nxt = remaining_q - LEN_WIDTH'(cur_n);
               end
            end
         end
         ST_PERM_WAIT: begin
            if (perm_done_i) state_nxt = ST_EMIT;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Next beat is recomputed every cycle; inputs held stable in EMIT keep it steady under backpressure
      n_nxt     = beat_len(rate_bytes_nxt, offset_nxt, remaining_nxt);
      shamt     = {offset_nxt, 3'b000};
      keep_nxt  = '0;
      byte_mask = '0;
      data_nxt  = '0;
      last_nxt  = 1'b0;
      if (state_nxt == ST_EMIT) begin
         keep_nxt = KEEP_WIDTH'((KW1'(1) << n_nxt) - KW1'(1));
         for (int j = 0; j < KEEP_WIDTH; j++) begin
            byte_mask[j*8 +: 8] = {8{keep_nxt[j]}};
         end
         data_nxt = DWIDTH'(flat >> shamt) & byte_mask;
         last_nxt = (LEN_WIDTH'(n_nxt) == remaining_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         offset_q     <= '0;
         remaining_q  <= '0;
         rate_bytes_q <= '0;
         data_o       <= '0;
         keep_o       <= '0;
         last_o       <= 1'b0;
         valid_o      <= 1'b0;
         perm_req_o   <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         offset_q     <= offset_nxt;
         remaining_q  <= remaining_nxt;
         rate_bytes_q <= rate_bytes_nxt;
         data_o       <= data_nxt;
         keep_o       <= keep_nxt;
         last_o       <= last_nxt;
         valid_o      <= (state_nxt == ST_EMIT);
         perm_req_o   <= (state_nxt == ST_PERM_WAIT);
         busy_o       <= (state_nxt != ST_IDLE);
         done_o       <= done_nxt;
      end
   end

endmodule
